instruction_memory_arbiter: RTL and testbench

Parametrised successor to the instruction-memory front end. Sits between the program-control fetch stage, the debug module's memory-access path and the external pipelined instruction RAM. It arbitrates one access per cycle between fetch and debug, and tracks in-flight reads through a latency-matched tag pipeline so each returned word goes to its owner. It extracts the 32-bit instruction lane from a wide memory word, and returns registered valid-qualified responses to both requesters.

---
 rtl/instruction_memory_arbiter.sv | 170 +++++++++++++++++
 tb/tb_instruction_memory_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_arbiter.sv
// instruction_memory_arbiter
//
// Instruction-memory front end shared by the fetch stage and the debug
// module's memory-access path. One access is granted per cycle, and debug
// has priority. Read ownership travels through a tag pipeline that matches
// the RAM latency, so each returned word goes back to its requester. Fetch
// responses carry the 32-bit lane that address bit 2 selects out of a
// 64-bit memory word.
//
// Parameters:
//   DATA_WIDTH         memory word width (32 or 64)
//   ADDR_WIDTH         byte address width
//   INSTRUCTION_WIDTH  instruction width (32)
//   MEM_LATENCY        cycles from read enable to read data (1..4)
//
// Ports:
//   im_clk, im_rst            clock, synchronous active-high reset
//   wdt_reset_i               watchdog flush request
//   fetch_*                   fetch request / grant / registered response
//   debug_mode_valid_i,
//   instr_mem_access_valid,
//   dbg_*                     debug request / grant / registered responses
//   debug_mem_read_data       full read word returned to debug
//   z_im_*                    pipelined instruction RAM interface
//
// Optional feature: ZILLA_IM_WDT_FLUSH_EN. When it is defined, wdt_reset_i
// blocks both grants in the current cycle and clears every in-flight tag.
// When it is not defined, wdt_reset_i is ignored.

module instruction_memory_arbiter #(
    parameter int DATA_WIDTH        = 64,
    parameter int ADDR_WIDTH        = 20,
    parameter int INSTRUCTION_WIDTH = 32,
    parameter int MEM_LATENCY       = 1
) (
    input  logic                         im_clk,
    input  logic                         im_rst,
    input  logic                         wdt_reset_i,
    input  logic                         fetch_req_i,
    input  logic [ADDR_WIDTH-1:0]        fetch_addr_i,
    output logic                         fetch_gnt_o,
    output logic                         fetch_rvalid_o,
    output logic [INSTRUCTION_WIDTH-1:0] instruction_o,
    input  logic                         debug_mode_valid_i,
    input  logic                         instr_mem_access_valid,
    input  logic                         dbg_req_i,
    input  logic                         dbg_we_i,
    input  logic [ADDR_WIDTH-1:0]        dbg_addr_i,
    input  logic [DATA_WIDTH-1:0]        dbg_wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      dbg_strobe_i,
    output logic                         dbg_gnt_o,
    output logic                         dbg_rvalid_o,
    output logic [DATA_WIDTH-1:0]        debug_mem_read_data,
    output logic                         dbg_wack_o,
    output logic                         z_im_write_en_o,
    output logic [ADDR_WIDTH-1:0]        z_im_write_addr_o,
    output logic [DATA_WIDTH-1:0]        z_im_write_data_o,
    output logic [DATA_WIDTH/8-1:0]      z_im_write_data_strobe_o,
    output logic                         z_im_read_en_o,
    output logic [ADDR_WIDTH-1:0]        z_im_read_addr_o,
    input  logic [DATA_WIDTH-1:0]        z_im_read_data_i
);

    logic flush;

`ifdef ZILLA_IM_WDT_FLUSH_EN
    assign flush = wdt_reset_i;
`else
    logic unused_wdt;
    assign flush      = 1'b0;
    assign unused_wdt = wdt_reset_i;
`endif

    logic dbg_grant;
    logic fetch_grant;
    logic dbg_read;
    logic dbg_write;

    // Debug wins any conflict. Fetch is locked out for the whole time the
    // hart is halted, whether or not debug is making a request.
    always_comb begin
        dbg_grant   = debug_mode_valid_i && instr_mem_access_valid && dbg_req_i && !flush;
        fetch_grant = fetch_req_i && !debug_mode_valid_i && !dbg_grant && !flush;
        dbg_write   = dbg_grant && dbg_we_i;
        dbg_read    = dbg_grant && !dbg_we_i;
    end

    assign fetch_gnt_o = fetch_grant;
    assign dbg_gnt_o   = dbg_grant;

    // RAM drive. Any field that is not in use is held at zero.
    always_comb begin
        z_im_write_en_o          = 1'b0;
        z_im_write_addr_o        = '0;
        z_im_write_data_o        = '0;
        z_im_write_data_strobe_o = '0;
        z_im_read_en_o           = 1'b0;
        z_im_read_addr_o         = '0;
        if (dbg_write) begin
            z_im_write_en_o          = 1'b1;
            z_im_write_addr_o        = dbg_addr_i;
            z_im_write_data_o        = dbg_wdata_i;
            z_im_write_data_strobe_o = dbg_strobe_i;
        end
        if (dbg_read) begin
            z_im_read_en_o   = 1'b1;
            z_im_read_addr_o = dbg_addr_i;
        end else if (fetch_grant) begin
            z_im_read_en_o   = 1'b1;
            z_im_read_addr_o = fetch_addr_i;
        end
    end

    // Tag pipeline: stage i describes the read issued i+1 cycles ago. The
    // tail stage lines up with the cycle in which the RAM data is valid.
    logic [MEM_LATENCY-1:0] tag_valid;
    logic [MEM_LATENCY-1:0] tag_owner;
    logic [MEM_LATENCY-1:0] tag_lane;

    always_ff @(posedge im_clk) begin
        if (im_rst || flush) begin
            tag_valid <= '0;
        end else begin
            tag_valid[0] <= z_im_read_en_o;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
            end
        end
        tag_owner[0] <= dbg_read;
        tag_lane[0]  <= z_im_read_addr_o[2];
        for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
            tag_owner[i] <= tag_owner[i-1];
            tag_lane[i]  <= tag_lane[i-1];
        end
    end

    logic                         tail_valid;
    logic                         tail_owner;
    logic [INSTRUCTION_WIDTH-1:0] lane_word;

    assign tail_valid = tag_valid[MEM_LATENCY-1];
    assign tail_owner = tag_owner[MEM_LATENCY-1];

    // When the memory word is 32 bits wide, both slices select the same
    // bits, so the lane bit has no effect.
    assign lane_word = (DATA_WIDTH == 64 && tag_lane[MEM_LATENCY-1])
                     ? z_im_read_data_i[DATA_WIDTH-1 -: INSTRUCTION_WIDTH]
                     : z_im_read_data_i[INSTRUCTION_WIDTH-1:0];

    always_ff @(posedge im_clk) begin
        if (im_rst) begin
            fetch_rvalid_o      <= 1'b0;
            dbg_rvalid_o        <= 1'b0;
            dbg_wack_o          <= 1'b0;
            instruction_o       <= '0;
            debug_mem_read_data <= '0;
        end else begin
            fetch_rvalid_o <= tail_valid && !tail_owner;
            dbg_rvalid_o   <= tail_valid && tail_owner;
            dbg_wack_o     <= dbg_write;
            if (tail_valid && !tail_owner) begin
                instruction_o <= lane_word;
            end
            if (tail_valid && tail_owner) begin
                debug_mem_read_data <= z_im_read_data_i;
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory_arbiter.sv
// Bench for instruction_memory_arbiter. Two instances share one set of
// request inputs. Instance 0 has MEM_LATENCY=2 and instance 1 has
// MEM_LATENCY=3. Each instance has its own RAM model. A per-cycle history of
// accepted requests predicts every output of both instances.

module tb_instruction_memory_arbiter;

    localparam int AW    = 20;
    localparam int DW    = 64;
    localparam int SW    = DW / 8;
    localparam int LAT_A = 2;
    localparam int LAT_B = 3;
    localparam int H     = 1024;
    localparam logic [DW-1:0] JUNK = 64'hDEAD_0BAD_DEAD_0BAD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1, wdt = 1'b0, fetch_req = 1'b0;
    logic          dmv = 1'b0, imav = 1'b0, dbg_req = 1'b0, dbg_we = 1'b0;
    logic [AW-1:0] fetch_addr = '0, dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic [SW-1:0] dbg_strobe = '0;

    logic          fgnt [2], frv [2], dgnt [2], drv [2], wack [2], wen [2], ren [2];
    logic [31:0]   instr [2];
    logic [DW-1:0] ddata [2], wdata [2], rdata [2];
    logic [AW-1:0] waddr [2], raddr [2];
    logic [SW-1:0] wstrb [2];

    instruction_memory_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(32), .MEM_LATENCY(LAT_A)
    ) u_dut_a (
        .im_clk(clk), .im_rst(rst), .wdt_reset_i(wdt),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fgnt[0]),
        .fetch_rvalid_o(frv[0]), .instruction_o(instr[0]),
        .debug_mode_valid_i(dmv), .instr_mem_access_valid(imav),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_strobe_i(dbg_strobe), .dbg_gnt_o(dgnt[0]),
        .dbg_rvalid_o(drv[0]), .debug_mem_read_data(ddata[0]), .dbg_wack_o(wack[0]),
        .z_im_write_en_o(wen[0]), .z_im_write_addr_o(waddr[0]),
        .z_im_write_data_o(wdata[0]), .z_im_write_data_strobe_o(wstrb[0]),
        .z_im_read_en_o(ren[0]), .z_im_read_addr_o(raddr[0]), .z_im_read_data_i(rdata[0])
    );

    instruction_memory_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INSTRUCTION_WIDTH(32), .MEM_LATENCY(LAT_B)
    ) u_dut_b (
        .im_clk(clk), .im_rst(rst), .wdt_reset_i(wdt),
        .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_gnt_o(fgnt[1]),
        .fetch_rvalid_o(frv[1]), .instruction_o(instr[1]),
        .debug_mode_valid_i(dmv), .instr_mem_access_valid(imav),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr),
        .dbg_wdata_i(dbg_wdata), .dbg_strobe_i(dbg_strobe), .dbg_gnt_o(dgnt[1]),
        .dbg_rvalid_o(drv[1]), .debug_mem_read_data(ddata[1]), .dbg_wack_o(wack[1]),
        .z_im_write_en_o(wen[1]), .z_im_write_addr_o(waddr[1]),
        .z_im_write_data_o(wdata[1]), .z_im_write_data_strobe_o(wstrb[1]),
        .z_im_read_en_o(ren[1]), .z_im_read_addr_o(raddr[1]), .z_im_read_data_i(rdata[1])
    );

    // Memory contents are a fixed function of the address. The 0x8000
    // doubleword holds the reference pattern.
    function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
        if (a[AW-1:3] == 17'h01000) return 64'h1111_2222_3333_4444;
        return {12'h000, a, 12'hA5A, a};
    endfunction

    function automatic int lat(input int d);
        return (d == 0) ? LAT_A : LAT_B;
    endfunction

    // RAM models: the address a DUT presents comes back LAT cycles later.
    logic [AW:0] pipe [2][4] = '{default: '0};
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pipe[d][0] <= {ren[d], raddr[d]};
            for (int k = 1; k < 4; k++) pipe[d][k] <= pipe[d][k-1];
        end
    end
    always_comb begin
        rdata[0] = pipe[0][LAT_A-1][AW] ? mem(pipe[0][LAT_A-1][AW-1:0]) : JUNK;
        rdata[1] = pipe[1][LAT_B-1][AW] ? mem(pipe[1][LAT_B-1][AW-1:0]) : JUNK;
    end

    int checks = 0;
    int errors = 0;
    int t = 0;

    task automatic chk(input int d, input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL L%0d %s: got %h expected %h (cycle %0d)", lat(d), nm, act, exp, t);
        end
    endtask

    // History of accepted requests, indexed by cycle.
    bit            h_rd [H], h_own [H], h_lane [H], h_wr [H], h_rst [H], h_fl [H];
    logic [AW-1:0] h_addr [H];

    // A read issued in cycle g is lost if reset occurs in any cycle from g
    // through its tail cycle g+L. It is also lost if a flush occurs before
    // it reaches the tail.
    function automatic bit alive(input int g, input int l);
        for (int c = g; c <= g + l; c++) if (h_rst[c]) return 1'b0;
`ifdef ZILLA_IM_WDT_FLUSH_EN
        for (int c = g; c < g + l; c++) if (h_fl[c]) return 1'b0;
`endif
        return 1'b1;
    endfunction

    logic [31:0]   exp_instr [2] = '{default: '0};
    logic [DW-1:0] exp_ddata [2] = '{default: '0};

    initial begin : compare
        bit fl, eg, ef, wr, rd, efrv, edrv, ewack;
        int g;
        logic [DW-1:0] w;
        forever begin
            @(negedge clk);
`ifdef ZILLA_IM_WDT_FLUSH_EN
            fl = wdt;
`else
            fl = 1'b0;
`endif
            eg = dmv && imav && dbg_req && !fl;
            ef = fetch_req && !dmv && !eg && !fl;
            wr = eg && dbg_we;
            rd = ef || (eg && !dbg_we);
            for (int d = 0; d < 2; d++) begin
                chk(d, "fetch_gnt", fgnt[d], ef);
                chk(d, "dbg_gnt", dgnt[d], eg);
                chk(d, "write_en", wen[d], wr);
                chk(d, "write_addr", waddr[d], wr ? dbg_addr : '0);
                chk(d, "write_data", wdata[d], wr ? dbg_wdata : '0);
                chk(d, "write_strobe", wstrb[d], wr ? dbg_strobe : '0);
                chk(d, "read_en", ren[d], rd);
                chk(d, "read_addr", raddr[d], rd ? (eg ? dbg_addr : fetch_addr) : '0);
            end
            if (t < H) begin
                h_rd[t]   = rd;
                h_own[t]  = eg;
                h_addr[t] = eg ? dbg_addr : fetch_addr;
                h_lane[t] = eg ? dbg_addr[2] : fetch_addr[2];
                h_wr[t]   = wr;
                h_rst[t]  = rst;
                h_fl[t]   = fl;
            end
            if (t > 0 && t < H) begin
                for (int d = 0; d < 2; d++) begin
                    efrv = 1'b0; edrv = 1'b0; ewack = 1'b0;
                    if (h_rst[t-1]) begin
                        exp_instr[d] = '0;
                        exp_ddata[d] = '0;
                    end else begin
                        ewack = h_wr[t-1];
                        g = t - 1 - lat(d);
                        if (g >= 0 && h_rd[g] && alive(g, lat(d))) begin
                            w = mem(h_addr[g]);
                            if (h_own[g]) begin
                                edrv = 1'b1;
                                exp_ddata[d] = w;
                            end else begin
                                efrv = 1'b1;
                                exp_instr[d] = h_lane[g] ? w[63:32] : w[31:0];
                            end
                        end
                    end
                    chk(d, "fetch_rvalid", frv[d], efrv);
                    chk(d, "dbg_rvalid", drv[d], edrv);
                    chk(d, "dbg_wack", wack[d], ewack);
                    chk(d, "instruction", instr[d], exp_instr[d]);
                    chk(d, "dbg_rdata", ddata[d], exp_ddata[d]);
                end
            end
            t++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_req = 1'b0; dbg_req = 1'b0; dbg_we = 1'b0; wdt = 1'b0; rst = 1'b0;
    endtask

    initial begin : stim
        int n_fa, n_fb, n_da, n_db;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Fetch 0x8004 selects the upper lane of 0x1111_2222_3333_4444.
        fetch_req = 1'b1; fetch_addr = 20'h08004;
        #1 chk(0, "t1 fetch granted", fgnt[0], 1);
        step(); idle();
        step(); chk(0, "t1 no early rvalid", frv[0], 0);
        step(); chk(0, "t1 rvalid at L+1", frv[0], 1);
        chk(0, "t1 upper lane", instr[0], 32'h1111_2222);
        chk(1, "t1 L3 not yet", frv[1], 0);
        step(); chk(1, "t1 L3 rvalid", frv[1], 1);
        chk(1, "t1 L3 upper lane", instr[1], 32'h1111_2222);
        chk(0, "t1 single pulse", frv[0], 0);
        chk(0, "t1 instr held", instr[0], 32'h1111_2222);

        // Debug write, with fetch also requesting while halted.
        dmv = 1'b1; imav = 1'b1; dbg_req = 1'b1; dbg_we = 1'b1;
        dbg_addr = 20'h08000; dbg_wdata = 64'hDEAD_BEEF_0000_0001; dbg_strobe = 8'hFF;
        fetch_req = 1'b1; fetch_addr = 20'h08008;
        #1;
        chk(0, "t2 write_en", wen[0], 1);
        chk(0, "t2 write_addr", waddr[0], 20'h08000);
        chk(0, "t2 write_data", wdata[0], 64'hDEAD_BEEF_0000_0001);
        chk(0, "t2 strobe", wstrb[0], 8'hFF);
        chk(0, "t2 no fetch gnt", fgnt[0], 0);
        step();
        chk(0, "t2 wack", wack[0], 1);
        chk(1, "t2 wack", wack[1], 1);
        dbg_req = 1'b0; dbg_we = 1'b0;
        #1 chk(0, "t2 fetch still blocked", fgnt[0], 0);
        step(); chk(0, "t2 wack one pulse", wack[0], 0);

        // Debug read and fetch in the same cycle: debug wins.
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 20'h08000;
        #1;
        chk(0, "t3 dbg gnt", dgnt[0], 1);
        chk(0, "t3 fetch gnt", fgnt[0], 0);
        step(); dbg_req = 1'b0; fetch_req = 1'b0;
        n_fa = 0; n_da = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            n_fa += int'(frv[0]);
            n_da += int'(drv[0]);
            if (i == 1) begin
                chk(0, "t3 dbg rvalid", drv[0], 1);
                chk(0, "t3 dbg data", ddata[0], 64'h1111_2222_3333_4444);
            end
        end
        chk(0, "t3 dbg pulses", n_da, 1);
        chk(0, "t3 fetch pulses", n_fa, 0);

        // Three fetches, then halt: the in-flight responses still go to fetch.
        dmv = 1'b0; imav = 1'b0; fetch_req = 1'b1;
        fetch_addr = 20'h00100; step();
        fetch_addr = 20'h00104; step();
        fetch_addr = 20'h00108; step();
        dmv = 1'b1;
        n_fa = 0; n_fb = 0; n_da = 0; n_db = 0;
        for (int i = 0; i < 6; i++) begin
            n_fa += int'(frv[0]); n_fb += int'(frv[1]);
            n_da += int'(drv[0]); n_db += int'(drv[1]);
            step();
        end
        chk(0, "t4 fetch pulses", n_fa, 3);
        chk(1, "t4 fetch pulses", n_fb, 3);
        chk(0, "t4 dbg pulses", n_da + n_db, 0);

        // Reset one cycle after a fetch grant drops the read.
        dmv = 1'b0; fetch_req = 1'b1; fetch_addr = 20'h00200;
        step(); fetch_req = 1'b0; rst = 1'b1;
        step(); rst = 1'b0;
        #1;
        chk(1, "t5 instr zero", instr[1], 0);
        chk(1, "t5 dbg data zero", ddata[1], 0);
        chk(1, "t5 rvalid zero", frv[1], 0);
        chk(1, "t5 read_en zero", ren[1], 0);
        chk(1, "t5 read_addr zero", raddr[1], 0);
        n_fa = 0; n_fb = 0;
        for (int i = 0; i < 6; i++) begin
            n_fa += int'(frv[0]); n_fb += int'(frv[1]);
            step();
        end
        chk(0, "t5 no rvalid after reset", n_fa, 0);
        chk(1, "t5 no rvalid after reset", n_fb, 0);

        // Watchdog pulse with two reads in flight.
        fetch_req = 1'b1; fetch_addr = 20'h00300; step();
        fetch_addr = 20'h00308; step();
        fetch_req = 1'b0; wdt = 1'b1; step();
        wdt = 1'b0;
        n_fb = 0;
        for (int i = 0; i < 6; i++) begin
            n_fb += int'(frv[1]);
            step();
        end
`ifdef ZILLA_IM_WDT_FLUSH_EN
        chk(1, "t6 flushed reads", n_fb, 0);
`else
        chk(1, "t6 delivered reads", n_fb, 2);
`endif

        idle();
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
